// File: rtl/mii_rx_byte_assembler.sv
// MII receive front end: strips preamble/SFD, pairs nibbles into bytes and emits per-frame terminators.
// Optional build macro RX_ERR_ABORT_EN: mii_rx_er inside a frame aborts it immediately.
module mii_rx_byte_assembler #(
    parameter int unsigned P_MIN_PREAMBLE = 8,
    parameter int unsigned P_MAX_BYTES    = 1522
) (
    input  logic        phy_clk,
    input  logic        phy_rst,
    input  logic        mii_rx_dv,
    input  logic [3:0]  mii_rxd,
    input  logic        mii_rx_er,
    output logic [8:0]  data_out,
    output logic        data_out_vld,
    output logic        frame_err,
    output logic [10:0] byte_cnt
);

    localparam logic [3:0]  LP_MIN_PRE = 4'(P_MIN_PREAMBLE);
    localparam logic [10:0] LP_MAX     = 11'(P_MAX_BYTES);

    typedef enum logic [1:0] {StIdle, StPreamble, StData, StWaitIdle} state_e;

    state_e      r_state, w_state_nxt;
    logic        r_dv, r_er;
    logic [3:0]  r_rxd;
    logic [3:0]  r_pre_cnt, w_pre_cnt_nxt;
    logic [3:0]  r_lo, w_lo_nxt;
    logic        r_have_lo, w_have_lo_nxt;
    logic        r_err, w_err_nxt;
    logic [10:0] r_byte_cnt, w_byte_cnt_nxt;
    logic [8:0]  r_data_out, w_data_out_nxt;
    logic        r_vld, w_vld_nxt;
    logic        r_frame_err, w_frame_err_nxt;
    logic        w_abort;

`ifdef RX_ERR_ABORT_EN
    assign w_abort = r_er;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge phy_clk or posedge phy_rst) begin
        if (phy_rst) begin
            r_dv        <= 1'b0;
            r_rxd       <= 4'h0;
            r_er        <= 1'b0;
            r_state     <= StIdle;
            r_pre_cnt   <= 4'h0;
            r_lo        <= 4'h0;
            r_have_lo   <= 1'b0;
            r_err       <= 1'b0;
            r_byte_cnt  <= 11'd0;
            r_data_out  <= 9'h000;
            r_vld       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_dv        <= mii_rx_dv;
            r_rxd       <= mii_rxd;
            r_er        <= mii_rx_er;
            r_state     <= w_state_nxt;
            r_pre_cnt   <= w_pre_cnt_nxt;
            r_lo        <= w_lo_nxt;
            r_have_lo   <= w_have_lo_nxt;
            r_err       <= w_err_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_data_out  <= w_data_out_nxt;
            r_vld       <= w_vld_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pre_cnt_nxt   = r_pre_cnt;
        w_lo_nxt        = r_lo;
        w_have_lo_nxt   = r_have_lo;
        w_err_nxt       = r_err;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_data_out_nxt  = r_data_out;
        w_vld_nxt       = 1'b0;
        w_frame_err_nxt = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_dv) begin
                    if (r_rxd == 4'h5) begin
                        w_state_nxt   = StPreamble;
                        w_pre_cnt_nxt = 4'd1;
                    end else begin
                        w_state_nxt = StWaitIdle;
                    end
                end
            end
            StPreamble: begin
                if (!r_dv) begin
                    w_state_nxt = StIdle;
                end else if (r_rxd == 4'h5) begin
                    if (r_pre_cnt != 4'hF) w_pre_cnt_nxt = r_pre_cnt + 4'd1;
                end else if (r_rxd == 4'hD && r_pre_cnt >= LP_MIN_PRE) begin
                    w_state_nxt    = StData;
                    w_byte_cnt_nxt = 11'd0;
                    w_err_nxt      = 1'b0;
                    w_have_lo_nxt  = 1'b0;
                end else begin
                    w_state_nxt = StWaitIdle;
                end
            end
            StData: begin
                if (!r_dv) begin
                    // A dangling low nibble is dropped but marks the frame bad.
                    w_data_out_nxt  = 9'h000;
                    w_vld_nxt       = 1'b1;
                    w_frame_err_nxt = r_err | r_have_lo;
                    w_have_lo_nxt   = 1'b0;
                    w_state_nxt     = StIdle;
                end else if (w_abort) begin
                    w_data_out_nxt  = 9'h000;
                    w_vld_nxt       = 1'b1;
                    w_frame_err_nxt = 1'b1;
                    w_err_nxt       = 1'b1;
                    w_have_lo_nxt   = 1'b0;
                    w_state_nxt     = StWaitIdle;
                end else if (!r_have_lo) begin
                    w_lo_nxt      = r_rxd;
                    w_have_lo_nxt = 1'b1;
                    w_err_nxt     = r_err | r_er;
                end else if (r_byte_cnt == LP_MAX) begin
                    // Overlength: the byte that would exceed the limit becomes the terminator.
                    w_data_out_nxt  = 9'h000;
                    w_vld_nxt       = 1'b1;
                    w_frame_err_nxt = 1'b1;
                    w_err_nxt       = 1'b1;
                    w_have_lo_nxt   = 1'b0;
                    w_state_nxt     = StWaitIdle;
                end else begin
                    w_data_out_nxt = {1'b1, r_rxd, r_lo};
                    w_vld_nxt      = 1'b1;
                    w_byte_cnt_nxt = r_byte_cnt + 11'd1;
                    w_have_lo_nxt  = 1'b0;
                    w_err_nxt      = r_err | r_er;
                end
            end
            StWaitIdle: begin
                if (!r_dv) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign data_out     = r_data_out;
    assign data_out_vld = r_vld;
    assign frame_err    = r_frame_err;
    assign byte_cnt     = r_byte_cnt;

endmodule
